// File: rtl/cordic_pkg.sv
// cordic_pkg: shared Q2.20 constants, atan table and FSM encoding for the CORDIC vectoring engine
package cordic_pkg;
  localparam int FRAC_BITS = 20;
  localparam int CNT_BITS = 4;
  localparam int ITERATIONS = 1 << CNT_BITS;
  localparam int PI = 3294199;
  localparam int PI_2 = 1647099;
  // atan(2^-i) in Q2.20; beyond i=9 the value is 2^-i to within rounding
  localparam int ATAN_TABLE [10] = '{823550, 486170, 256879, 130396, 65451, 32757, 16383, 8192, 4096, 2048};
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
endpackage

// File: rtl/cordic_atan_lut.sv
// cordic_atan_lut: combinational atan(2^-i) lookup in Q2.20
module cordic_atan_lut
  import cordic_pkg::*;
#(
  parameter int CW = CNT_BITS,
  parameter int DW = 22
) (
  input  logic [CW-1:0] iter_i,
  output logic [DW-1:0] atan_o
);
  always_comb atan_o = (32'(iter_i) < 10) ? DW'(ATAN_TABLE[iter_i]) :
                       (32'(iter_i) <= FRAC_BITS) ? DW'(1 << (FRAC_BITS - 32'(iter_i))) : '0;
endmodule

// File: rtl/cordic_vectoring_engine.sv
// cordic_vectoring_engine: iterative CORDIC in vectoring mode, returning atan2(y,x) and the
// unscaled (K-gain) magnitude of a Q2.20 vector with valid/ready handshakes on both sides.
module cordic_vectoring_engine
  import cordic_pkg::*;
#(
  parameter int INTEGER_WIDTH = 2,
  parameter int DECIMAL_WIDTH = FRAC_BITS,
  parameter int DATA_WIDTH = INTEGER_WIDTH + DECIMAL_WIDTH,
  parameter int CORDIC_COUNTER_WIDTH = CNT_BITS
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clk_en,
  input  logic                         valid_in,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] x_in,
  input  logic signed [DATA_WIDTH-1:0] y_in,
  output logic                         valid_out,
  input  logic                         ready_in,
  output logic signed [DATA_WIDTH:0]   angle_out,
  output logic signed [DATA_WIDTH-1:0] magnitude_out
);
  localparam int DW = DATA_WIDTH;
  localparam int XW = DATA_WIDTH + 2;
  localparam int ZW = DATA_WIDTH + 1;
  localparam int CW = CORDIC_COUNTER_WIDTH;
  localparam logic signed [XW-1:0] MAG_MAX = XW'((1 << (DW - 1)) - 1);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic signed [XW-1:0] x_q, x_d, y_q, y_d, x_e, y_e, x_it, y_it;
  logic signed [ZW-1:0] z_q, z_d, z_it, step, angle_q, angle_d;
  logic signed [DW-1:0] mag_q, mag_d;
  logic [DW-1:0] atan_w;
  logic pos, last, zero_in, x_neg, y_neg;
  cordic_atan_lut #(.CW(CW), .DW(DW)) u_lut (.iter_i(cnt_q), .atan_o(atan_w));
  assign x_e = XW'(x_in);
  assign y_e = XW'(y_in);
  assign x_neg = x_in[DW-1];
  assign y_neg = y_in[DW-1];
  assign zero_in = (x_in == '0) && (y_in == '0);
  assign step = {1'b0, atan_w};
  // rotate toward y=0; the sign of y picks the direction of each micro-rotation
  assign pos = ~y_q[XW-1];
  assign x_it = pos ? x_q + (y_q >>> cnt_q) : x_q - (y_q >>> cnt_q);
  assign y_it = pos ? y_q - (x_q >>> cnt_q) : y_q + (x_q >>> cnt_q);
  assign z_it = pos ? z_q + step : z_q - step;
  assign last = 32'(cnt_q) == ITERATIONS - 1;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    x_d = x_q;
    y_d = y_q;
    z_d = z_q;
    angle_d = angle_q;
    mag_d = mag_q;
    case (state_q)
      IDLE: if (clk_en && valid_in) begin
        state_d = zero_in ? DONE : RUN;
        cnt_d = '0;
        x_d = !x_neg ? x_e : (!y_neg ? y_e : -y_e);
        y_d = !x_neg ? y_e : (!y_neg ? -x_e : x_e);
        z_d = !x_neg ? '0 : (!y_neg ? ZW'(PI_2) : -ZW'(PI_2));
        angle_d = zero_in ? '0 : angle_q;
        mag_d = zero_in ? '0 : mag_q;
      end
      RUN: if (clk_en) begin
        x_d = x_it;
        y_d = y_it;
        z_d = z_it;
        cnt_d = cnt_q + CW'(1);
        state_d = last ? DONE : RUN;
        angle_d = last ? z_it : angle_q;
        mag_d = !last ? mag_q : (x_it > MAG_MAX) ? MAG_MAX[DW-1:0] : x_it[DW-1:0];
      end
      DONE: state_d = (clk_en && ready_in) ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      x_q <= '0;
      y_q <= '0;
      z_q <= '0;
      angle_q <= '0;
      mag_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      x_q <= x_d;
      y_q <= y_d;
      z_q <= z_d;
      angle_q <= angle_d;
      mag_q <= mag_d;
    end
  end
  assign in_ready = state_q == IDLE;
  assign valid_out = state_q == DONE;
  assign angle_out = angle_q;
  assign magnitude_out = mag_q;
endmodule
